ub_read_streamer: RTL and testbench
===================================

# ub_read_streamer

Read-side counterpart to the unified buffer's two-lane write port. Takes a read command with start address and word count, issues synchronous reads to the buffer memory two words per cycle, and streams the words out on two lanes with valid/ready backpressure. It sits between the unified buffer storage and the systolic-array input feeders.

## Interface

- UNIFIED_BUFFER_WIDTH, 50, number of 16-bit words in buffer memory
- DATA_WIDTH, 16, word width
- ADDR_WIDTH, 9, address and length width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid_in  in  1  command present
- cmd_ready_out  out  1  block can accept a command
- cmd_addr_in  in  ADDR_WIDTH  first word address
- cmd_len_in  in  ADDR_WIDTH  number of words to read
- mem_rd_en_out  out  1  memory read strobe
- mem_rd_addr_1_out, mem_rd_addr_2_out  out  ADDR_WIDTH  lane addresses
- mem_rd_data_1_in, mem_rd_data_2_in  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en_out
- ub_read_data_1_out, ub_read_data_2_out  out  DATA_WIDTH  streamed words
- ub_read_valid_1_out, ub_read_valid_2_out  out  1  per-lane valid
- ub_read_ready_in  in  1  consumer accepts current pair
- busy_out  out  1  command in progress
- done_out  out  1  one-cycle pulse at command completion
- err_out  out  1  one-cycle pulse, command out of range

## Operation

- FSM: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: cmd_ready_out=1. Handshake (cmd_valid_in && cmd_ready_out) latches addr/len; range check in ADDR_WIDTH+1 bits: addr+len > UNIFIED_BUFFER_WIDTH -> FINISH with error, no reads; len==0 -> FINISH, no reads; else ISSUE.
- ISSUE: each issue reads rd_ptr (lane 1) and rd_ptr+1 (lane 2), rd_ptr += 2, remaining -= 2. If remaining==1, lane 2 not used: addr_2 driven 0, stored pair has v2=0, rd_ptr += 1. Last issue -> DRAIN.
- Issue permitted when fifo_count + inflight − pop_this_cycle < 2 (credit scheme; 1 in-flight read max).
- Returning data written into a 2-entry pair FIFO with its lane-valid bits.
- Output pair presented from FIFO head; valid_1/valid_2 = head valid bits, both 0 when empty. Pop on (ub_read_valid_1_out && ub_read_ready_in). Lane 2 never valid without lane 1.
- DRAIN: wait until inflight==0 and FIFO empty -> FINISH.
- FINISH: done_out=1 for one cycle (err_out=1 too if range error) -> IDLE.
- busy_out=1 in ISSUE, DRAIN, FINISH.
- No address wrap: out-of-range commands rejected whole.

## Timing

- Reset (rst low, async): state IDLE, FIFO empty, pointers/counters 0; cmd_ready_out=1, all other outputs 0. Reset mid-command abandons it; no done_out.
- Accept at cycle T -> first mem_rd_en_out at T+1 -> data into FIFO at T+2 -> first ub_read_valid_1_out at T+3.
- Ready held high: one pair per cycle sustained, no bubbles.
- done_out asserted cycle after final pop handshake.
- Error/zero-length: done_out (and err_out) at T+1, cmd_ready_out back at T+2.
- Ready low: data held stable, issue stalls after FIFO+inflight reach 2; no data loss or duplication.
- Command accepted only in IDLE; cmd_valid_in otherwise ignored.

## Structure

- Shared package ub_pkg: DATA_WIDTH, ADDR_WIDTH constants, ub_pair_t struct {data_1, data_2, valid_1, valid_2}, ub_rd_state_t enum.
- Sub-module ub_pair_fifo: 2-entry FIFO of ub_pair_t with push/pop, count, full/empty; same async active-low reset.

## Test plan

- Memory preloaded word i = 0x0100+i; cmd addr 4 len 6, ready high -> pairs (0x0104,0x0105),(0x0106,0x0107),(0x0108,0x0109) at T+3..T+5, done_out at T+6.
- cmd addr 10 len 5 -> third pair valid_1=1 data 0x010E, valid_2=0; exactly 5 words output.
- cmd addr 0 len 8, ready toggling 1-0-0-1 -> sequence 0x0100..0x0107 in order, no drops/duplicates, outputs stable while ready low.
- cmd addr 48 len 3 (width 50) -> err_out and done_out at T+1, mem_rd_en_out never asserted; cmd addr 48 len 2 -> one pair (0x0130,0x0131).
- cmd len 0 -> done_out at T+1, no valids; rst pulsed low mid-stream of len-20 command -> all outputs 0 immediately, cmd_ready_out=1, next command runs correctly.

Source files
------------

// File: rtl/ub_pkg.sv
// Shared types and default sizes for the unified-buffer read path.
package ub_pkg;

  localparam int DATA_WIDTH           = 16;
  localparam int ADDR_WIDTH           = 9;
  localparam int UNIFIED_BUFFER_WIDTH = 50;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data_1;
    logic [DATA_WIDTH-1:0] data_2;
    logic                  valid_1;
    logic                  valid_2;
  } ub_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } ub_rd_state_t;

endpackage

// File: rtl/ub_pair_fifo.sv
// Two-entry FIFO of word pairs; pointers/count reset, payload storage does not.
module ub_pair_fifo
  import ub_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  ub_pair_t   din_i,
  input  logic       pop_i,
  output ub_pair_t   head_o,
  output logic [1:0] count_o,
  output logic       empty_o
);

  logic [1:0] count_q, count_d;
  logic       wr_q, rd_q;
  logic       full;
  logic       do_push, do_pop;
  ub_pair_t   mem_q [0:1];

  assign full    = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    else if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ub_read_streamer.sv
// Streams a contiguous word range out of the unified buffer, two words per
// cycle, with a one-read-in-flight credit loop into a two-pair output FIFO.
module ub_read_streamer #(
  parameter int UNIFIED_BUFFER_WIDTH = ub_pkg::UNIFIED_BUFFER_WIDTH,
  parameter int DATA_WIDTH           = ub_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH           = ub_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [ADDR_WIDTH-1:0] cmd_len_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_1_out,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_2_out,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_1_in,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_2_in,
  output logic [DATA_WIDTH-1:0] ub_read_data_1_out,
  output logic [DATA_WIDTH-1:0] ub_read_data_2_out,
  output logic                  ub_read_valid_1_out,
  output logic                  ub_read_valid_2_out,
  input  logic                  ub_read_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  import ub_pkg::*;

  // Range check is done one bit wider so addr+len cannot wrap.
  function automatic logic range_bad(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] len);
    logic [ADDR_WIDTH:0] end_w;
    end_w = {1'b0, addr} + {1'b0, len};
    return end_w > (ADDR_WIDTH+1)'(UNIFIED_BUFFER_WIDTH);
  endfunction

  ub_rd_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  err_q, err_d;
  logic                  inflight_q, inflight_v2_q;

  logic                  accept, pop, issue, can_issue, lane2_used, last_issue;
  logic [ADDR_WIDTH-1:0] step;
  logic [2:0]            credit_used;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  ub_pair_t              fifo_din, fifo_head;

  assign accept      = cmd_valid_in && cmd_ready_out;
  assign pop         = ub_read_valid_1_out && ub_read_ready_in;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign can_issue   = credit_used < (3'd2 + {2'b00, pop});
  assign issue       = (state_q == ST_ISSUE) && can_issue;
  assign lane2_used  = (rem_q != ADDR_WIDTH'(1));
  assign step        = lane2_used ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
  assign last_issue  = issue && (rem_q <= ADDR_WIDTH'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (range_bad(cmd_addr_in, cmd_len_in) || (cmd_len_in == '0)) state_d = ST_FINISH;
          else                                                         state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
      // Leaving on the final pop puts done_out in the very next cycle.
      ST_DRAIN: begin
        if (!inflight_q && (fifo_empty || ((fifo_count == 2'd1) && pop))) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_out     = 1'b0;
    busy_out          = 1'b0;
    done_out          = 1'b0;
    err_out           = 1'b0;
    mem_rd_en_out     = 1'b0;
    mem_rd_addr_1_out = '0;
    mem_rd_addr_2_out = '0;
    case (state_q)
      ST_IDLE:  cmd_ready_out = 1'b1;
      ST_ISSUE: begin
        busy_out      = 1'b1;
        mem_rd_en_out = issue;
        if (issue) begin
          mem_rd_addr_1_out = ptr_q;
          if (lane2_used) mem_rd_addr_2_out = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: busy_out = 1'b1;
      ST_FINISH: begin
        busy_out = 1'b1;
        done_out = 1'b1;
        err_out  = err_q;
      end
      default: cmd_ready_out = 1'b0;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    err_d = err_q;
    if (accept) begin
      ptr_d = cmd_addr_in;
      rem_d = cmd_len_in;
      err_d = range_bad(cmd_addr_in, cmd_len_in);
    end else if (issue) begin
      ptr_d = ptr_q + step;
      rem_d = rem_q - step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      rem_q         <= '0;
      err_q         <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_v2_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      err_q         <= err_d;
      inflight_q    <= issue;
      inflight_v2_q <= issue && lane2_used;
    end
  end

  // Memory returns data exactly one cycle after the strobe.
  always_comb begin
    fifo_din         = '0;
    fifo_din.data_1  = mem_rd_data_1_in;
    fifo_din.data_2  = inflight_v2_q ? mem_rd_data_2_in : '0;
    fifo_din.valid_1 = 1'b1;
    fifo_din.valid_2 = inflight_v2_q;
  end

  ub_pair_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign ub_read_valid_1_out = !fifo_empty && fifo_head.valid_1;
  assign ub_read_valid_2_out = ub_read_valid_1_out && fifo_head.valid_2;
  assign ub_read_data_1_out  = ub_read_valid_1_out ? fifo_head.data_1 : '0;
  assign ub_read_data_2_out  = ub_read_valid_2_out ? fifo_head.data_2 : '0;

endmodule

// File: tb/tb_ub_read_streamer.sv
// Directed bench for ub_read_streamer against a 50-word synchronous memory model.
module tb_ub_read_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_addr, cmd_len;
  logic        rd_en;
  logic [8:0]  rd_addr_1, rd_addr_2;
  logic [15:0] rd_data_1, rd_data_2;
  logic [15:0] d1, d2;
  logic        v1, v2;
  logic        rdy;
  logic        busy, done, err;

  logic [15:0] mem [0:49];
  int          rd_count = 0;
  int          total = 0, passed = 0, failed = 0;

  always #5 clk = ~clk;

  ub_read_streamer dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid_in        (cmd_valid),
    .cmd_ready_out       (cmd_ready),
    .cmd_addr_in         (cmd_addr),
    .cmd_len_in          (cmd_len),
    .mem_rd_en_out       (rd_en),
    .mem_rd_addr_1_out   (rd_addr_1),
    .mem_rd_addr_2_out   (rd_addr_2),
    .mem_rd_data_1_in    (rd_data_1),
    .mem_rd_data_2_in    (rd_data_2),
    .ub_read_data_1_out  (d1),
    .ub_read_data_2_out  (d2),
    .ub_read_valid_1_out (v1),
    .ub_read_valid_2_out (v2),
    .ub_read_ready_in    (rdy),
    .busy_out            (busy),
    .done_out            (done),
    .err_out             (err)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_1 <= (rd_addr_1 < 9'd50) ? mem[rd_addr_1] : 16'hDEAD;
      rd_data_2 <= (rd_addr_2 < 9'd50) ? mem[rd_addr_2] : 16'hDEAD;
      rd_count  <= rd_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input logic ev1, input logic [15:0] ed1,
                          input logic ev2, input logic [15:0] ed2);
    chk({tag, "_v1"}, {31'd0, v1}, {31'd0, ev1});
    chk({tag, "_d1"}, {16'd0, d1}, {16'd0, ed1});
    chk({tag, "_v2"}, {31'd0, v2}, {31'd0, ev2});
    chk({tag, "_d2"}, {16'd0, d2}, {16'd0, ed2});
  endtask

  task automatic chk_rd(input string tag, input logic een, input logic [8:0] ea1, input logic [8:0] ea2);
    chk({tag, "_en"}, {31'd0, rd_en}, {31'd0, een});
    chk({tag, "_a1"}, {23'd0, rd_addr_1}, {23'd0, ea1});
    chk({tag, "_a2"}, {23'd0, rd_addr_2}, {23'd0, ea2});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk_pair(tag, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] a, input logic [8:0] l);
    cyc();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_w;
    logic [15:0] held_d1, held_d2;
    logic        held_v2, stalled, got_done;
    int          rd_before;

    for (int i = 0; i < 50; i++) mem[i] = 16'h0100 + 16'(i);
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    cyc(); rst = 1'b1;

    // Test 1: addr 4 len 6, ready held high
    rdy = 1'b1;
    send(9'd4, 9'd6);
    chk("t1_T_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t1_T_rd_en", {31'd0, rd_en}, 32'd0);
    cyc(); cmd_valid = 1'b0; @(negedge clk);
    chk_rd("t1_T1", 1'b1, 9'd4, 9'd5);
    chk("t1_T1_busy", {31'd0, busy}, 32'd1);
    chk("t1_T1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t1_T1_v1", {31'd0, v1}, 32'd0);
    cyc(); @(negedge clk);
    chk_rd("t1_T2", 1'b1, 9'd6, 9'd7);
    chk("t1_T2_v1", {31'd0, v1}, 32'd0);
    cyc(); @(negedge clk);
    chk_pair("t1_T3", 1'b1, 16'h0104, 1'b1, 16'h0105);
    chk_rd("t1_T3", 1'b1, 9'd8, 9'd9);
    cyc(); @(negedge clk);
    chk_pair("t1_T4", 1'b1, 16'h0106, 1'b1, 16'h0107);
    chk("t1_T4_rd_en", {31'd0, rd_en}, 32'd0);
    cyc(); @(negedge clk);
    chk_pair("t1_T5", 1'b1, 16'h0108, 1'b1, 16'h0109);
    chk("t1_T5_done", {31'd0, done}, 32'd0);
    cyc(); @(negedge clk);
    chk("t1_T6_done", {31'd0, done}, 32'd1);
    chk("t1_T6_err", {31'd0, err}, 32'd0);
    chk("t1_T6_v1", {31'd0, v1}, 32'd0);
    cyc(); @(negedge clk);
    chk_idle("t1_T7");

    // Test 2: addr 10 len 5, odd tail uses lane 1 only
    send(9'd10, 9'd5);
    cyc(); cmd_valid = 1'b0; @(negedge clk);
    chk_rd("t2_T1", 1'b1, 9'd10, 9'd11);
    cyc(); @(negedge clk);
    chk_rd("t2_T2", 1'b1, 9'd12, 9'd13);
    cyc(); @(negedge clk);
    chk_pair("t2_T3", 1'b1, 16'h010A, 1'b1, 16'h010B);
    chk_rd("t2_T3", 1'b1, 9'd14, 9'd0);
    cyc(); @(negedge clk);
    chk_pair("t2_T4", 1'b1, 16'h010C, 1'b1, 16'h010D);
    cyc(); @(negedge clk);
    chk_pair("t2_T5", 1'b1, 16'h010E, 1'b0, 16'h0000);
    cyc(); @(negedge clk);
    chk("t2_T6_done", {31'd0, done}, 32'd1);
    chk_pair("t2_T6", 1'b0, 16'h0, 1'b0, 16'h0);
    cyc(); @(negedge clk);
    chk_idle("t2_T7");

    // Test 3: addr 0 len 8, ready pattern 1-0-0-1
    send(9'd0, 9'd8);
    exp_w = 16'h0100; stalled = 1'b0; got_done = 1'b0;
    held_d1 = '0; held_d2 = '0; held_v2 = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      cyc();
      cmd_valid = 1'b0;
      rdy = ((i % 4) == 0) || ((i % 4) == 3);
      @(negedge clk);
      if (stalled) begin
        chk("t3_hold_v1", {31'd0, v1}, 32'd1);
        chk("t3_hold_d1", {16'd0, d1}, {16'd0, held_d1});
        chk("t3_hold_v2", {31'd0, v2}, {31'd0, held_v2});
        chk("t3_hold_d2", {16'd0, d2}, {16'd0, held_d2});
      end
      stalled = v1 && !rdy;
      held_d1 = d1; held_d2 = d2; held_v2 = v2;
      if (v1 && rdy) begin
        chk("t3_d1", {16'd0, d1}, {16'd0, exp_w});
        exp_w = exp_w + 16'd1;
        if (v2) begin
          chk("t3_d2", {16'd0, d2}, {16'd0, exp_w});
          exp_w = exp_w + 16'd1;
        end
      end
      if (done) got_done = 1'b1;
    end
    chk("t3_done_seen", {31'd0, got_done}, 32'd1);
    chk("t3_word_count", {16'd0, exp_w}, 32'h0108);
    rdy = 1'b1;
    cyc(); @(negedge clk);
    chk_idle("t3_end");

    // Test 4: out-of-range rejected, then the last legal pair
    rd_before = rd_count;
    send(9'd48, 9'd3);
    chk("t4_T_rd_en", {31'd0, rd_en}, 32'd0);
    cyc(); cmd_valid = 1'b0; @(negedge clk);
    chk("t4_T1_done", {31'd0, done}, 32'd1);
    chk("t4_T1_err", {31'd0, err}, 32'd1);
    chk("t4_T1_rd_en", {31'd0, rd_en}, 32'd0);
    chk("t4_T1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cyc(); @(negedge clk);
    chk_idle("t4_T2");
    chk("t4_no_reads", rd_count, rd_before);
    send(9'd48, 9'd2);
    cyc(); cmd_valid = 1'b0; @(negedge clk);
    chk_rd("t4b_T1", 1'b1, 9'd48, 9'd49);
    cyc(); @(negedge clk);
    chk("t4b_T2_rd_en", {31'd0, rd_en}, 32'd0);
    cyc(); @(negedge clk);
    chk_pair("t4b_T3", 1'b1, 16'h0130, 1'b1, 16'h0131);
    cyc(); @(negedge clk);
    chk("t4b_T4_done", {31'd0, done}, 32'd1);
    chk("t4b_T4_err", {31'd0, err}, 32'd0);
    chk("t4b_T4_v1", {31'd0, v1}, 32'd0);

    // Test 5: zero length
    cyc(); @(negedge clk);
    rd_before = rd_count;
    send(9'd5, 9'd0);
    cyc(); cmd_valid = 1'b0; @(negedge clk);
    chk("t5_T1_done", {31'd0, done}, 32'd1);
    chk("t5_T1_err", {31'd0, err}, 32'd0);
    chk("t5_T1_v1", {31'd0, v1}, 32'd0);
    cyc(); @(negedge clk);
    chk_idle("t5_T2");
    chk("t5_no_reads", rd_count, rd_before);

    // Test 6: reset mid-stream, then a fresh command
    send(9'd20, 9'd20);
    repeat (3) begin cyc(); cmd_valid = 1'b0; end
    @(negedge clk);
    chk_pair("t6_T3", 1'b1, 16'h0114, 1'b1, 16'h0115);
    cyc(); @(negedge clk);
    chk_pair("t6_T4", 1'b1, 16'h0116, 1'b1, 16'h0117);
    cyc(); rst = 1'b0; #1;
    chk_idle("t6_in_reset");
    cyc(); rst = 1'b1; @(negedge clk);
    chk_idle("t6_after_reset");
    send(9'd2, 9'd4);
    cyc(); cmd_valid = 1'b0; @(negedge clk);
    chk_rd("t6b_T1", 1'b1, 9'd2, 9'd3);
    cyc(); @(negedge clk);
    chk_rd("t6b_T2", 1'b1, 9'd4, 9'd5);
    cyc(); @(negedge clk);
    chk_pair("t6b_T3", 1'b1, 16'h0102, 1'b1, 16'h0103);
    cyc(); @(negedge clk);
    chk_pair("t6b_T4", 1'b1, 16'h0104, 1'b1, 16'h0105);
    cyc(); @(negedge clk);
    chk("t6b_T5_done", {31'd0, done}, 32'd1);
    cyc(); @(negedge clk);
    chk_idle("t6b_T6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
